// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter/sequencer that shares one 32-bit ALU between two requesters.
// It keeps a separate NZCV flag context for each requester and registers every response.
module alu_share_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IV_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_reg1,
    input  logic [DATA_W-1:0] req0_reg2,
    input  logic [IV_W-1:0]   req0_iv,
    input  logic [3:0]        req0_opcode,
    input  logic [3:0]        req0_cond,
    input  logic              req0_s,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_reg1,
    input  logic [DATA_W-1:0] req1_reg2,
    input  logic [IV_W-1:0]   req1_iv,
    input  logic [3:0]        req1_opcode,
    input  logic [3:0]        req1_cond,
    input  logic              req1_s,

    output logic [DATA_W-1:0] alu_reg1,
    output logic [DATA_W-1:0] alu_reg2,
    output logic [IV_W-1:0]   alu_iv,
    output logic [3:0]        alu_opcode,
    output logic [3:0]        alu_cond,
    output logic              alu_s,
    output logic [3:0]        alu_flag,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_new_flag,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic [3:0]        rsp_flag,

    output logic [3:0]        flags0,
    output logic [3:0]        flags1
);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t            state, state_nx;
    logic              grant;
    logic              last_grant;
    logic              accept;
    logic [DATA_W-1:0] op_reg1, op_reg2;
    logic [IV_W-1:0]   op_iv;
    logic [3:0]        op_opcode, op_cond;
    logic              op_s, op_id;
    logic [3:0]        cur_flag;

    // A tie goes to the requester that was not served last.
    always_comb begin
        if (req0_valid && req1_valid) grant = ~last_grant;
        else                          grant = req1_valid;
    end

    assign req0_ready = (state == IDLE) && req0_valid && !grant;
    assign req1_ready = (state == IDLE) && req1_valid &&  grant;
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)    state_nx = ISSUE;
            ISSUE:                  state_nx = HOLD;
            HOLD:    if (rsp_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg1   <= '0;
            op_reg2   <= '0;
            op_iv     <= '0;
            op_opcode <= '0;
            op_cond   <= '0;
            op_s      <= 1'b0;
            op_id     <= 1'b0;
        end else if (accept) begin
            op_id     <= grant;
            op_reg1   <= grant ? req1_reg1   : req0_reg1;
            op_reg2   <= grant ? req1_reg2   : req0_reg2;
            op_iv     <= grant ? req1_iv     : req0_iv;
            op_opcode <= grant ? req1_opcode : req0_opcode;
            op_cond   <= grant ? req1_cond   : req0_cond;
            op_s      <= grant ? req1_s      : req0_s;
        end
    end

    assign cur_flag = op_id ? flags1 : flags0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags0     <= '0;
            flags1     <= '0;
            rsp_result <= '0;
            rsp_flag   <= '0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (state == ISSUE) begin
                rsp_result <= alu_result;
                rsp_id     <= op_id;
                rsp_flag   <= op_s ? alu_new_flag : cur_flag;
                if (op_s && !op_id) flags0 <= alu_new_flag;
                if (op_s &&  op_id) flags1 <= alu_new_flag;
            end
            if (state == HOLD && rsp_ready) last_grant <= rsp_id;
        end
    end

    assign alu_reg1   = op_reg1;
    assign alu_reg2   = op_reg2;
    assign alu_iv     = op_iv;
    assign alu_opcode = op_opcode;
    assign alu_cond   = op_cond;
    assign alu_s      = (state == ISSUE) && op_s;
    assign alu_flag   = cur_flag;
    assign rsp_valid  = (state == HOLD);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with an ADD-only ALU stub and hand-computed expectations.
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_s;
    logic [31:0] req0_reg1, req0_reg2;
    logic [15:0] req0_iv;
    logic [3:0]  req0_opcode, req0_cond;
    logic        req1_valid, req1_ready, req1_s;
    logic [31:0] req1_reg1, req1_reg2;
    logic [15:0] req1_iv;
    logic [3:0]  req1_opcode, req1_cond;
    logic [31:0] alu_reg1, alu_reg2, alu_result;
    logic [15:0] alu_iv;
    logic [3:0]  alu_opcode, alu_cond, alu_flag, alu_new_flag;
    logic        alu_s;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flag, flags0, flags1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.DATA_W(32), .IV_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_reg1(req0_reg1),
        .req0_reg2(req0_reg2), .req0_iv(req0_iv), .req0_opcode(req0_opcode),
        .req0_cond(req0_cond), .req0_s(req0_s),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_reg1(req1_reg1),
        .req1_reg2(req1_reg2), .req1_iv(req1_iv), .req1_opcode(req1_opcode),
        .req1_cond(req1_cond), .req1_s(req1_s),
        .alu_reg1(alu_reg1), .alu_reg2(alu_reg2), .alu_iv(alu_iv),
        .alu_opcode(alu_opcode), .alu_cond(alu_cond), .alu_s(alu_s),
        .alu_flag(alu_flag), .alu_result(alu_result), .alu_new_flag(alu_new_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flag(rsp_flag),
        .flags0(flags0), .flags1(flags1)
    );

    // ALU stub: opcode 0000 is ADD with NZCV of the sum
    logic [32:0] sum;
    always_comb begin
        sum          = {1'b0, alu_reg1} + {1'b0, alu_reg2};
        alu_result   = '0;
        alu_new_flag = '0;
        if (alu_opcode == 4'b0000) begin
            alu_result   = sum[31:0];
            alu_new_flag = {sum[31], sum[31:0] == 32'd0, sum[32],
                            (alu_reg1[31] == alu_reg2[31]) && (sum[31] != alu_reg1[31])};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
    endtask

    // Present one op, wait (bounded) for its grant, return ALU-port view during ISSUE.
    task automatic send(input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic s, output logic [3:0] iss_flag, output logic iss_s);
        bit got = 1'b0;
        if (id) begin
            req1_valid = 1; req1_reg1 = a; req1_reg2 = b; req1_s = s;
            req1_opcode = 4'b0000; req1_cond = 4'hE; req1_iv = 16'h1234;
        end else begin
            req0_valid = 1; req0_reg1 = a; req0_reg2 = b; req0_s = s;
            req0_opcode = 4'b0000; req0_cond = 4'hE; req0_iv = 16'h1234;
        end
        #1;
        for (int i = 0; i < 8; i++) begin
            if (id ? req1_ready : req0_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        chk("grant_timeout", {31'd0, got}, 32'd1);
        @(posedge clk);
        @(negedge clk); #1;
        iss_flag = alu_flag;
        iss_s    = alu_s;
        if (id) req1_valid = 0; else req0_valid = 0;
    endtask

    typedef struct {
        bit          id;
        logic [31:0] a, b;
        logic        s;
        logic [31:0] res;
        logic [3:0]  rf, f0, f1;
    } vec_t;
    vec_t vecs[6];

    int exp_g[12] = '{0, -1, -1, 1, -1, -1, 0, -1, -1, 1, -1, -1};
    int exp_r[12] = '{-1, -1, 0, -1, -1, 1, -1, -1, 0, -1, -1, 1};

    initial begin
        logic [3:0] fl;
        logic       sv;
        int         g, r;

        vecs[0] = '{0, 32'h6000_0000, 32'h2000_0001, 1, 32'h8000_0001, 4'b1001, 4'b1001, 4'b0000};
        vecs[1] = '{1, 32'h6000_0000, 32'h2000_0001, 0, 32'h8000_0001, 4'b0000, 4'b1001, 4'b0000};
        vecs[2] = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0000, 4'b0110, 4'b1001, 4'b0110};
        vecs[3] = '{0, 32'h8000_0000, 32'h8000_0000, 1, 32'h0000_0000, 4'b0111, 4'b0111, 4'b0110};
        vecs[4] = '{0, 32'd5,         32'd7,         0, 32'd12,        4'b0111, 4'b0111, 4'b0110};
        vecs[5] = '{1, 32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h8000_0000, 4'b1001, 4'b0111, 4'b1001};

        rst_n = 0; rsp_ready = 1;
        req0_valid = 0; req0_reg1 = 0; req0_reg2 = 0; req0_iv = 0; req0_opcode = 0; req0_cond = 0; req0_s = 0;
        req1_valid = 0; req1_reg1 = 0; req1_reg2 = 0; req1_iv = 0; req1_opcode = 0; req1_cond = 0; req1_s = 0;
        @(negedge clk); #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_id_flag", {27'd0, rsp_id, rsp_flag}, 0);
        chk("rst_flags", {24'd0, flags0, flags1}, 0);
        chk("rst_alu_reg1", alu_reg1, 0);
        chk("rst_alu_ctl", {15'd0, alu_iv, alu_s}, 0);
        rst_n = 1;
        @(negedge clk); #1;

        // Single-requester vectors; flag context carries from one vector to the next
        for (int v = 0; v < 6; v++) begin
            send(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].s, fl, sv);
            chk("vec_issue_s", {31'd0, sv}, {31'd0, vecs[v].s});
            chk("vec_lat_issue", {31'd0, rsp_valid}, 0);
            @(negedge clk); #1;
            chk("vec_lat_hold", {31'd0, rsp_valid}, 1);
            chk("vec_result", rsp_result, vecs[v].res);
            chk("vec_rsp_flag", {28'd0, rsp_flag}, {28'd0, vecs[v].rf});
            chk("vec_rsp_id", {31'd0, rsp_id}, {31'd0, vecs[v].id});
            chk("vec_flags", {24'd0, flags0, flags1}, {24'd0, vecs[v].f0, vecs[v].f1});
            chk("vec_hold_alu_s", {31'd0, alu_s}, 0);
            @(negedge clk); #1;
            chk("vec_done", {31'd0, rsp_valid}, 0);
        end

        // Round-robin with both requesters continuously valid
        do_reset();
        req0_reg1 = 1; req0_reg2 = 2; req0_s = 0; req0_opcode = 0;
        req1_reg1 = 3; req1_reg2 = 4; req1_s = 0; req1_opcode = 0;
        req0_valid = 1; req1_valid = 1; rsp_ready = 1;
        #1;
        for (int c = 0; c < 12; c++) begin
            g = req0_ready ? 0 : (req1_ready ? 1 : -1);
            r = rsp_valid ? int'(rsp_id) : -1;
            chk("rr_grant", g, exp_g[c]);
            chk("rr_rsp", r, exp_r[c]);
            if (rsp_valid) chk("rr_result", rsp_result, rsp_id ? 32'd7 : 32'd3);
            @(negedge clk); #1;
        end
        req0_valid = 0; req1_valid = 0;
        @(negedge clk); #1;

        // Stall in HOLD with rsp_ready low
        do_reset();
        rsp_ready = 0;
        send(0, 32'd10, 32'd20, 1, fl, sv);
        req1_reg1 = 1; req1_reg2 = 1; req1_s = 0; req1_valid = 1;
        @(negedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", {31'd0, rsp_valid}, 1);
            chk("stall_payload", rsp_result, 32'd30);
            chk("stall_id_flag", {27'd0, rsp_id, rsp_flag}, 0);
            chk("stall_readies", {30'd0, req0_ready, req1_ready}, 0);
            @(negedge clk); #1;
        end
        rsp_ready = 1;
        @(negedge clk); #1;
        chk("stall_resume", {30'd0, req0_ready, req1_ready}, 32'd1);
        send(1, 32'd1, 32'd1, 0, fl, sv);
        @(negedge clk); #1;
        chk("stall_next_result", rsp_result, 32'd2);
        @(negedge clk); #1;

        // Back-to-back ops from req0 see the previous op's flags
        do_reset();
        send(0, 32'd5, 32'd7, 1, fl, sv);
        chk("fwd_op1_flag", {28'd0, fl}, 0);
        @(negedge clk); #1;
        chk("fwd_op1_res", rsp_result, 32'd12);
        @(negedge clk); #1;
        send(0, 32'h7FFF_FFFF, 32'd1, 1, fl, sv);
        chk("fwd_op2_flag", {28'd0, fl}, 0);
        @(negedge clk); #1;
        chk("fwd_op2_flags0", {28'd0, flags0}, 32'b1001);
        @(negedge clk); #1;
        send(0, 32'd1, 32'd1, 1, fl, sv);
        chk("fwd_op3_flag", {28'd0, fl}, 32'b1001);
        chk("fwd_op3_s", {31'd0, sv}, 1);
        @(negedge clk); #1;
        chk("fwd_op3_flags", {24'd0, flags0, flags1}, 0);
        @(negedge clk); #1;

        // Reset during ISSUE aborts the op and clears both flag contexts
        send(0, 32'h7FFF_FFFF, 32'd1, 1, fl, sv);
        @(negedge clk); #1;
        @(negedge clk); #1;
        send(0, 32'hFFFF_FFFF, 32'd1, 1, fl, sv);
        rst_n = 0;
        #1;
        chk("abort_valid", {31'd0, rsp_valid}, 0);
        chk("abort_flags", {24'd0, flags0, flags1}, 0);
        @(negedge clk); #1;
        rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk("abort_no_rsp", {31'd0, rsp_valid}, 0);
        end
        req1_reg1 = 9; req1_reg2 = 9; req1_s = 1; req1_valid = 1;
        req0_valid = 1;
        #1;
        chk("abort_prio", {30'd0, req0_ready, req1_ready}, 32'd2);
        req1_valid = 0;
        send(0, 32'd2, 32'd3, 1, fl, sv);
        @(negedge clk); #1;
        chk("abort_next_res", rsp_result, 32'd5);
        chk("abort_next_flags", {24'd0, flags0, flags1}, 0);
        @(negedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
